// File: rtl/gyro_spi_pkg.sv
// Shared constants for the gyro SPI responder: register addresses, reset values and FSM encoding.
package gyro_spi_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_CTRL2    = 6'h21;
    localparam logic [5:0] ADDR_CTRL3    = 6'h22;
    localparam logic [5:0] ADDR_CTRL4    = 6'h23;
    localparam logic [5:0] ADDR_CTRL5    = 6'h24;
    localparam logic [5:0] ADDR_OUT_TEMP = 6'h26;
    localparam logic [5:0] ADDR_STATUS   = 6'h27;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

    localparam logic [7:0] CTRL1_RST = 8'h07;
    localparam logic [7:0] CTRL_RST  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with single-cycle rise/fall pulses.
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // No reset here: a reset mid-frame must not fabricate an ss_n edge when it releases.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], din};
        prev_q <= sync_q[STAGES-1];
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/gyro_spi_responder.sv
// L3G4200D-compatible SPI mode-3 responder: 64x8 register map, sample shadows, CTRL_REG1..5.
module gyro_spi_responder
    import gyro_spi_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        sample_valid,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    input  logic [7:0]  temp_in,
    output logic [7:0]  ctrl_reg1,
    output logic        busy,
    output state_t      fsm_state
);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;
    logic unused_sclk_level, unused_ss_level, unused_mosi_rise, unused_mosi_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(GCLK), .din(sclk), .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(GCLK), .din(ss_n), .level(unused_ss_level), .rise(ss_rise), .fall(ss_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(GCLK), .din(mosi), .level(mosi_bit), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [7:0]  rd_shift;
    logic [5:0]  addr_q;
    logic        burst_q;
    logic        zh_read_q;
    logic [7:0]  ctrl1, ctrl2, ctrl3, ctrl4, ctrl5;
    logic [7:0]  temp_q;
    logic [15:0] x_q, y_q, z_q;
    logic        zyxda_q, zyxor_q;
    logic        pend_valid_q;
    logic [15:0] pend_x, pend_y, pend_z;
    logic [7:0]  pend_temp;

    logic [7:0] rx_byte;
    logic [5:0] next_addr;
    logic       byte_done;

    assign rx_byte   = {shift_q, mosi_bit};
    assign next_addr = burst_q ? addr_q + 6'd1 : addr_q;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign ctrl_reg1 = ctrl1;

    function automatic logic [7:0] read_reg(input logic [5:0] a);
        case (a)
            ADDR_WHO_AM_I: return WHO_AM_I_VAL;
            ADDR_CTRL1:    return ctrl1;
            ADDR_CTRL2:    return ctrl2;
            ADDR_CTRL3:    return ctrl3;
            ADDR_CTRL4:    return ctrl4;
            ADDR_CTRL5:    return ctrl5;
            ADDR_OUT_TEMP: return temp_q;
            ADDR_STATUS:   return {zyxor_q, 3'b000, zyxda_q, 3'b000};
            ADDR_OUT_X_L:  return x_q[7:0];
            ADDR_OUT_X_H:  return x_q[15:8];
            ADDR_OUT_Y_L:  return y_q[7:0];
            ADDR_OUT_Y_H:  return y_q[15:8];
            ADDR_OUT_Z_L:  return z_q[7:0];
            ADDR_OUT_Z_H:  return z_q[15:8];
            default:       return 8'h00;
        endcase
    endfunction

    always_ff @(posedge GCLK) begin
        if (RST) begin
            fsm_state <= ST_IDLE;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 3'd0;
            shift_q   <= 7'd0;
            rd_shift  <= 8'd0;
            addr_q    <= 6'd0;
            burst_q   <= 1'b0;
            zh_read_q <= 1'b0;
            ctrl1     <= CTRL1_RST;
            ctrl2     <= CTRL_RST;
            ctrl3     <= CTRL_RST;
            ctrl4     <= CTRL_RST;
            ctrl5     <= CTRL_RST;
        end else if (ss_rise) begin
            // Frame end drops any partial byte: nothing below commits without byte_done.
            fsm_state <= ST_IDLE;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_state)
                ST_IDLE: if (ss_fall) begin
                    fsm_state <= ST_ADDR;
                    miso_oe   <= 1'b1;
                    busy      <= 1'b1;
                    bit_cnt   <= 3'd0;
                    zh_read_q <= 1'b0;
                end
                ST_ADDR: if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shift_q <= rx_byte[6:0];
                    if (byte_done) begin
                        burst_q <= shift_q[5];
                        addr_q  <= rx_byte[5:0];
                        if (shift_q[6]) begin
                            fsm_state <= ST_RD;
                            rd_shift  <= read_reg(rx_byte[5:0]);
                        end else begin
                            fsm_state <= ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (sclk_fall) begin
                        miso     <= rd_shift[7];
                        rd_shift <= {rd_shift[6:0], 1'b0};
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            if (addr_q == ADDR_OUT_Z_H) zh_read_q <= 1'b1;
                            addr_q   <= next_addr;
                            rd_shift <= read_reg(next_addr);
                        end
                    end
                end
                ST_WR: if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shift_q <= rx_byte[6:0];
                    if (byte_done) begin
                        case (addr_q)
                            ADDR_CTRL1: ctrl1 <= rx_byte;
                            ADDR_CTRL2: ctrl2 <= rx_byte;
                            ADDR_CTRL3: ctrl3 <= rx_byte;
                            ADDR_CTRL4: ctrl4 <= rx_byte;
                            ADDR_CTRL5: ctrl5 <= rx_byte;
                            default: ;
                        endcase
                        addr_q <= next_addr;
                    end
                end
                default: fsm_state <= ST_IDLE;
            endcase
        end
    end

    // A pulse landing on the frame-end cycle is applied directly and supersedes the pending copy.
    logic apply_direct, apply_pend, clear_flags, da_base, or_base;
    assign apply_direct = sample_valid && (!busy || ss_rise);
    assign apply_pend   = ss_rise && pend_valid_q && !sample_valid;
    assign clear_flags  = ss_rise && zh_read_q;
    assign da_base      = zyxda_q && !clear_flags;
    assign or_base      = zyxor_q && !clear_flags;

    always_ff @(posedge GCLK) begin
        if (RST) begin
            temp_q       <= 8'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            z_q          <= 16'd0;
            zyxda_q      <= 1'b0;
            zyxor_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_x       <= 16'd0;
            pend_y       <= 16'd0;
            pend_z       <= 16'd0;
            pend_temp    <= 8'd0;
        end else begin
            if (ss_rise) begin
                pend_valid_q <= 1'b0;
            end else if (sample_valid && busy) begin
                pend_valid_q <= 1'b1;
                pend_x       <= x_in;
                pend_y       <= y_in;
                pend_z       <= z_in;
                pend_temp    <= temp_in;
            end
            if (apply_direct || apply_pend) begin
                x_q     <= apply_direct ? x_in    : pend_x;
                y_q     <= apply_direct ? y_in    : pend_y;
                z_q     <= apply_direct ? z_in    : pend_z;
                temp_q  <= apply_direct ? temp_in : pend_temp;
                zyxda_q <= 1'b1;
                zyxor_q <= or_base || da_base;
            end else begin
                zyxda_q <= da_base;
                zyxor_q <= or_base;
            end
        end
    end

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Self-checking bench: bit-banged SPI master, transaction-level register-map model, per-cycle compare.
module tb_gyro_spi_responder;
    import gyro_spi_pkg::*;

    logic        GCLK = 1'b0;
    logic        RST = 1'b1;
    logic        sclk = 1'b1;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, busy;
    logic        sample_valid = 1'b0;
    logic [15:0] x_in = 16'd0, y_in = 16'd0, z_in = 16'd0;
    logic [7:0]  temp_in = 8'd0;
    logic [7:0]  ctrl_reg1;
    state_t      fsm_state;

    gyro_spi_responder dut (
        .GCLK(GCLK), .RST(RST), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .sample_valid(sample_valid),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in),
        .ctrl_reg1(ctrl_reg1), .busy(busy), .fsm_state(fsm_state));

    always #5 GCLK = ~GCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the register map
    logic [7:0]  m_ctrl [5];
    logic [7:0]  m_temp;
    logic [15:0] m_x, m_y, m_z;
    logic        m_da, m_or;
    logic        p_valid;
    logic [15:0] p_x, p_y, p_z;
    logic [7:0]  p_t;
    logic [15:0] s_x, s_y, s_z;
    logic [7:0]  s_t;

    logic       settled = 1'b0;
    logic       exp_active = 1'b0;
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl[0] = 8'h07;
        for (int i = 1; i < 5; i++) m_ctrl[i] = 8'h00;
        m_temp = 8'h00; m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
        m_da = 1'b0; m_or = 1'b0; p_valid = 1'b0;
    endfunction

    function automatic void model_apply(input logic [15:0] x, y, z, input logic [7:0] t);
        m_x = x; m_y = y; m_z = z; m_temp = t;
        m_or = m_or | m_da;
        m_da = 1'b1;
    endfunction

    function automatic logic [7:0] m_read(input logic [5:0] a);
        if (a == 6'h0F) return 8'hD3;
        if (a >= 6'h20 && a <= 6'h24) return m_ctrl[a - 6'h20];
        if (a == 6'h26) return m_temp;
        if (a == 6'h27) return {m_or, 3'b000, m_da, 3'b000};
        if (a >= 6'h28 && a <= 6'h2D) begin
            logic [47:0] all_axes;
            all_axes = {m_z, m_y, m_x};
            return all_axes[8*(a - 6'h28) +: 8];
        end
        return 8'h00;
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [7:0] d);
        if (a >= 6'h20 && a <= 6'h24) m_ctrl[a - 6'h20] = d;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge GCLK);
        #1;
    endtask

    task automatic sample_pulse(input logic [15:0] x, y, z, input logic [7:0] t);
        x_in = x; y_in = y; z_in = z; temp_in = t;
        sample_valid = 1'b1;
        wait_cyc(1);
        sample_valid = 1'b0;
        if (exp_active) begin
            p_valid = 1'b1; p_x = x; p_y = y; p_z = z; p_t = t;
        end else begin
            model_apply(x, y, z, t);
        end
    endtask

    task automatic lo_half(input logic b, input int half, output logic smp);
        sclk = 1'b0; mosi = b; settled = 1'b0;
        wait_cyc(4);
        settled = 1'b1;
        wait_cyc(half - 4);
        smp = miso;
    endtask

    task automatic hi_half(input int half);
        sclk = 1'b1; settled = 1'b0;
        wait_cyc(4);
        settled = 1'b1;
        wait_cyc(half - 4);
    endtask

    // One SPI frame: command plus nbytes, with the last drop_bits bits cut off by ss_n rising.
    task automatic run_frame(input logic [7:0] cmd, input int nbytes, input int drop_bits,
                             input int half, input int pulse_byte);
        logic       rw, ms, smp, zh;
        logic [5:0] a;
        logic [7:0] cap, tx, exp;
        int         total;
        rd_q.delete();
        rw = cmd[7]; ms = cmd[6]; a = cmd[5:0]; zh = 1'b0; cap = 8'h00;
        ss_n = 1'b0; settled = 1'b0; exp_active = 1'b1;
        wait_cyc(4);
        settled = 1'b1;
        wait_cyc(half);
        total = 8 * (nbytes + 1) - drop_bits;
        for (int i = 0; i < total; i++) begin
            if (i >= 8 && i % 8 == 0 && (i / 8 - 1) == pulse_byte)
                sample_pulse(s_x, s_y, s_z, s_t);
            if (i < 8) tx = cmd;
            else if (rw) tx = 8'h00;
            else tx = wr_q[i / 8 - 1];
            lo_half(tx[7 - (i % 8)], half, smp);
            cap = {cap[6:0], smp};
            if (i >= 8 && i % 8 == 7) begin
                if (rw) begin
                    exp = m_read(a);
                    rd_q.push_back(cap);
                    check($sformatf("rd_byte@%02h", a), cap, exp);
                    if (a == 6'h2D) zh = 1'b1;
                end else begin
                    m_write(a, wr_q[i / 8 - 1]);
                end
                if (ms) a = a + 6'd1;
            end
            hi_half(half);
        end
        ss_n = 1'b1; settled = 1'b0; exp_active = 1'b0;
        if (zh) begin m_da = 1'b0; m_or = 1'b0; end
        if (p_valid) begin model_apply(p_x, p_y, p_z, p_t); p_valid = 1'b0; end
        wait_cyc(4);
        settled = 1'b1;
        wait_cyc(6);
    endtask

    always @(negedge GCLK) begin
        if (settled && !RST) begin
            check("miso_oe", {7'd0, miso_oe}, {7'd0, exp_active});
            check("busy", {7'd0, busy}, {7'd0, exp_active});
            check("ctrl_reg1", ctrl_reg1, m_ctrl[0]);
            if (!exp_active) check("fsm_idle", {6'd0, fsm_state}, {6'd0, ST_IDLE});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic smp;
        logic [7:0] cmd;
        int nb, drop, half, pb;
        model_reset();
        wait_cyc(6);
        RST = 1'b0;
        wait_cyc(1);
        check("rst_miso", {7'd0, miso}, 8'h00);
        check("rst_oe", {7'd0, miso_oe}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_ctrl1", ctrl_reg1, 8'h07);
        check("rst_state", {6'd0, fsm_state}, {6'd0, ST_IDLE});
        settled = 1'b1;
        wait_cyc(4);

        // WHO_AM_I at 1 MHz sclk
        run_frame(8'h8F, 1, 0, 50, -1);
        check("whoami", rd_q[0], 8'hD3);

        // Burst write CTRL1/CTRL2, burst read back
        wr_q = '{8'h0F, 8'h00};
        run_frame(8'h60, 2, 0, 7, -1);
        check("ctrl1_wr", ctrl_reg1, 8'h0F);
        run_frame(8'hE0, 2, 0, 6, -1);
        check("rd_ctrl1", rd_q[0], 8'h0F);
        check("rd_ctrl2", rd_q[1], 8'h00);

        // Sample then burst read of temp..Z_H
        sample_pulse(16'h1234, 16'hABCD, 16'h8001, 8'h19);
        run_frame(8'hE6, 8, 0, 6, -1);
        check("b_temp", rd_q[0], 8'h19);
        check("b_stat", rd_q[1], 8'h08);
        check("b_xl", rd_q[2], 8'h34);
        check("b_xh", rd_q[3], 8'h12);
        check("b_yl", rd_q[4], 8'hCD);
        check("b_yh", rd_q[5], 8'hAB);
        check("b_zl", rd_q[6], 8'h01);
        check("b_zh", rd_q[7], 8'h80);
        run_frame(8'hA7, 1, 0, 6, -1);
        check("stat_cleared", rd_q[0], 8'h00);

        // Overrun, then a pulse mid-burst stays pending until frame end
        sample_pulse(16'h1234, 16'hABCD, 16'h8001, 8'h19);
        sample_pulse(16'h1234, 16'hABCD, 16'h8001, 8'h19);
        run_frame(8'hA7, 1, 0, 6, -1);
        check("stat_ovr", rd_q[0], 8'h88);
        s_x = 16'h5555; s_y = 16'hABCD; s_z = 16'h8001; s_t = 8'h19;
        run_frame(8'hE8, 6, 0, 6, 2);
        check("old_xl", rd_q[0], 8'h34);
        check("old_xh", rd_q[1], 8'h12);
        run_frame(8'hE8, 2, 0, 6, -1);
        check("new_xl", rd_q[0], 8'h55);
        check("new_xh", rd_q[1], 8'h55);
        run_frame(8'hA7, 1, 0, 6, -1);
        check("stat_pend_wins", rd_q[0], 8'h08);

        // Reset in the middle of a read frame
        ss_n = 1'b0; settled = 1'b0; exp_active = 1'b1;
        wait_cyc(4);
        settled = 1'b1;
        wait_cyc(6);
        cmd = 8'h8F;
        for (int i = 0; i < 10; i++) begin
            lo_half((i < 8) ? cmd[7 - i] : 1'b0, 6, smp);
            hi_half(6);
        end
        RST = 1'b1; settled = 1'b0;
        wait_cyc(1);
        check("rst_mid_oe", {7'd0, miso_oe}, 8'h00);
        check("rst_mid_busy", {7'd0, busy}, 8'h00);
        RST = 1'b0;
        model_reset();
        exp_active = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lo_half(1'b1, 6, smp);
            hi_half(6);
        end
        ss_n = 1'b1; settled = 1'b0;
        wait_cyc(4);
        settled = 1'b1;
        wait_cyc(6);
        check("rst_mid_ctrl1", ctrl_reg1, 8'h07);
        run_frame(8'h8F, 1, 0, 6, -1);
        check("whoami_after_rst", rd_q[0], 8'hD3);

        // Address wrap and non-incrementing reads
        run_frame(8'hFF, 2, 0, 5, -1);
        check("wrap_3f", rd_q[0], 8'h00);
        check("wrap_00", rd_q[1], 8'h00);
        run_frame(8'hA0, 3, 0, 5, -1);
        for (int i = 0; i < 3; i++) check("ms0_ctrl1", rd_q[i], 8'h07);

        // Partial data byte is discarded
        wr_q = '{8'hFF};
        run_frame(8'h20, 1, 3, 6, -1);
        check("partial_wr", ctrl_reg1, 8'h07);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            logic [5:0] a;
            case ($urandom_range(0, 4))
                0: a = 6'h0F;
                1: a = 6'(32'h20 + $urandom_range(0, 5));
                2: a = 6'(32'h26 + $urandom_range(0, 7));
                3: a = 6'(32'h3E + $urandom_range(0, 1));
                default: a = 6'($urandom_range(0, 63));
            endcase
            cmd  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a};
            nb   = $urandom_range(1, 4);
            drop = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 7) : 0;
            half = $urandom_range(5, 10);
            pb   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            s_x = 16'($urandom); s_y = 16'($urandom); s_z = 16'($urandom); s_t = 8'($urandom);
            wr_q.delete();
            for (int k = 0; k < nb; k++) wr_q.push_back(8'($urandom));
            if ($urandom_range(0, 4) < 2)
                sample_pulse(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
            run_frame(cmd, nb, drop, half, pb);
        end

        settled = 1'b0;
        wait_cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
